// File: rtl/vx_gbar_collector.sv
// vx_gbar_collector: global barrier responder that collects per-ID core arrivals and broadcasts releases
module vx_gbar_collector #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 16,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            req_valid,
  input  logic [NUM_CORES*NB_WIDTH-1:0]   req_id,
  input  logic [NUM_CORES*NC_WIDTH-1:0]   req_size_m1,
  input  logic [NUM_CORES*NC_WIDTH-1:0]   req_core_id,
  output logic [NUM_CORES-1:0]            req_ready,
  output logic                            rsp_valid,
  output logic [NB_WIDTH-1:0]             rsp_id
);
  logic [NUM_CORES-1:0] mask [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  ptr, gnt, sel_sz, sel_core;
  logic [NB_WIDTH-1:0]  sel_id;
  logic [NUM_CORES-1:0] cur, bit_c, nxt;
  logic [NC_WIDTH:0]    cnt;
  logic                 xfer, id_ok, rel;
  int                   idx;
  // round-robin grant: first valid core at or after ptr, wrapping
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CORES;
      if (req_valid[idx]) gnt = NC_WIDTH'(idx);
    end
  end
  assign xfer      = |req_valid;
  assign req_ready = xfer ? (NUM_CORES'(1) << gnt) : '0;
  assign sel_id    = req_id[gnt*NB_WIDTH +: NB_WIDTH];
  assign sel_sz    = req_size_m1[gnt*NC_WIDTH +: NC_WIDTH];
  assign sel_core  = req_core_id[gnt*NC_WIDTH +: NC_WIDTH];
  // merge the arriving core into the ID's mask and decide whether it releases
  always_comb begin
    id_ok = int'(sel_id) < NUM_BARRIERS;
    bit_c = (int'(sel_core) < NUM_CORES) ? (NUM_CORES'(1) << sel_core) : '0;
    cur   = id_ok ? mask[sel_id] : '0;
    nxt   = cur | bit_c;
    cnt   = '0;
    for (int i = 0; i < NUM_CORES; i++) cnt = cnt + (NC_WIDTH+1)'(nxt[i]);
    rel   = xfer && id_ok && (cnt >= ({1'b0, sel_sz} + 1'b1));
  end
  // masks, arbitration pointer and registered release pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) mask[b] <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (xfer && id_ok) mask[sel_id] <= rel ? '0 : nxt;
      if (xfer) ptr <= (int'(gnt) == NUM_CORES - 1) ? '0 : NC_WIDTH'(gnt + 1'b1);
      rsp_valid <= rel;
      if (rel) rsp_id <= sel_id;
    end
  end
endmodule

// File: tb/tb_vx_gbar_collector.sv
// tb_vx_gbar_collector: directed and randomized checks of the barrier collector against a set-based model
module tb_vx_gbar_collector;
  localparam int NC = 4, NB = 16, NBW = 4, NCW = 2;
  logic clk = 0, reset = 1;
  logic [NC-1:0] req_valid, req_ready;
  logic [NC*NBW-1:0] req_id;
  logic [NC*NCW-1:0] req_size_m1, req_core_id;
  logic rsp_valid;
  logic [NBW-1:0] rsp_id;
  int ncmp = 0, nfail = 0;
  logic [NC-1:0] tv = '0;
  int tid[NC], tsz[NC], tcr[NC];
  int mptr, gl, exp_id;
  bit exp_v;
  bit arr[NB][NC];

  vx_gbar_collector #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
    .req_size_m1(req_size_m1), .req_core_id(req_core_id), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req_valid = tv;
    for (int i = 0; i < NC; i++) begin
      req_id[i*NBW +: NBW] = NBW'(tid[i]);
      req_size_m1[i*NCW +: NCW] = NCW'(tsz[i]);
      req_core_id[i*NCW +: NCW] = NCW'(tcr[i]);
    end
  endtask

  task automatic model_reset();
    mptr = 0; exp_v = 0; exp_id = 0;
    for (int b = 0; b < NB; b++) for (int c = 0; c < NC; c++) arr[b][c] = 0;
  endtask

  task automatic do_reset(input bit keep);
    if (!keep) tv = '0;
    reset = 1;
    apply();
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    tv = '0;
  endtask

  task automatic step(input string tag);
    int cnt;
    apply();
    #4;
    gl = -1;
    for (int k = 0; k < NC; k++)
      if (gl < 0 && tv[(mptr + k) % NC]) gl = (mptr + k) % NC;
    check({tag, "_ready"}, 32'(req_ready), gl >= 0 ? (32'd1 << gl) : 0);
    exp_v = 0;
    if (gl >= 0) begin
      if (tcr[gl] < NC) arr[tid[gl]][tcr[gl]] = 1;
      cnt = 0;
      for (int c = 0; c < NC; c++) cnt += int'(arr[tid[gl]][c]);
      if (cnt >= tsz[gl] + 1) begin
        for (int c = 0; c < NC; c++) arr[tid[gl]][c] = 0;
        exp_v = 1;
        exp_id = tid[gl];
      end
      mptr = (gl + 1) % NC;
    end
    @(posedge clk); #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_v));
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
    if (gl >= 0) tv[gl] = 0;
  endtask

  task automatic set_req(input int i, input int id, input int sz, input int cr);
    tv[i] = 1; tid[i] = id; tsz[i] = sz; tcr[i] = cr;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin tid[i] = 0; tsz[i] = 0; tcr[i] = 0; end
    model_reset();
    do_reset(0);
    for (int i = 0; i < NC; i++) begin set_req(i, 5, 3, i); step("seq5"); end
    check("seq5_released", 32'(rsp_valid), 1);
    for (int i = 0; i < NC; i++) set_req(i, 2, 3, i);
    for (int k = 0; k < NC; k++) step("all2");
    check("all2_released", 32'(rsp_id), 2);
    check("all2_ptr", 32'(mptr), 0);
    set_req(0, 1, 1, 0); set_req(1, 3, 1, 1); set_req(2, 1, 1, 2); set_req(3, 3, 1, 3);
    for (int k = 0; k < NC; k++) step("ileave");
    set_req(1, 7, 1, 1); step("dup_a");
    set_req(1, 7, 1, 1); step("dup_b");
    set_req(2, 7, 1, 2); step("dup_rel");
    set_req(0, 7, 1, 0); step("dup_clr0");
    set_req(3, 7, 1, 3); step("dup_clr1");
    for (int k = 0; k < 8; k++) begin
      set_req(0, 8, 3, 0); set_req(3, 9, 3, 3);
      step("fair");
      check("fair_alt", 32'(gl), (k % 2 == 0) ? 0 : 3);
    end
    do_reset(0);
    for (int i = 0; i < 3; i++) begin set_req(i, 4, 3, i); step("mid4"); end
    do_reset(0);
    set_req(3, 4, 3, 3); step("mid4_post");
    for (int i = 0; i < NC; i++) begin set_req(i, 4, 3, i); step("mid4_full"); end
    set_req(0, 6, 0, 0);
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++)
        if (!tv[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : i);
      if (n == 200) do_reset(0);
      else step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
